// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the digit-counter width helper.
package digit_serial_adder_pkg;

  // Operation sequencing states; encodings are fixed so that other
  // datapath blocks decoding them stay in step.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count NDIG digits; never less than one bit so a
  // single-digit configuration still has a legal counter.
  function automatic int cnt_width(input int ndig);
    if (ndig <= 1) begin
      return 1;
    end else begin
      return $clog2(ndig);
    end
  endfunction

endpackage

// File: rtl/digit_serial_adder_fa.sv
// fa_slice: combinational ripple of DIGIT one-bit full adders. This is the
// only arithmetic hardware in the serial adder; it is reused every cycle.
module fa_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]    = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1]  = (x[i] & y[i]) | (y[i] & c_s[i]) | (x[i] & c_s[i]);
  end

  assign cout = c_s[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder that processes DIGIT bits per clock,
// LSB digit first, with the carry held in a flip-flop between digits.
// Start/done handshake; one operation takes WIDTH/DIGIT RUN cycles.
// Optional subtract mode is enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             cout_s;
  logic [WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_s),
    .cout (cout_s)
  );

  // New digit enters at the MSB end; with a single digit it is the whole sum.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign acc_shift_s = dig_s;
  end else begin : g_acc_shift
    assign acc_shift_s = {dig_s, acc_q[WIDTH-1:DIGIT]};
  end

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so only the loaded B and carry differ.
  assign b_load_s = sub ? ~b : b;
  assign c_load_s = sub ? 1'b1 : ci;
`else
  assign b_load_s = b;
  assign c_load_s = ci;
`endif

  // State, datapath and result registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath control: load on start, shift one digit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b_load_s;
          carry_d = c_load_s;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift_s;
        carry_d = cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          s_d     = acc_shift_s;
          co_d    = cout_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder. Four configurations run side
// by side (W/D = 8/1, 8/4, 8/8, 16/2); results are compared with plain
// integer arithmetic. Subtract tests appear when DIGIT_SERIAL_ADDER_SUB_EN
// is defined.
module tb_digit_serial_adder;

  logic clk;
  logic rst;

  logic        start_v [4];
  logic [15:0] a_v     [4];
  logic [15:0] b_v     [4];
  logic        ci_v    [4];
  logic        sub_v   [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        co_v    [4];
  logic [15:0] s_v     [4];

  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic        co0, co1, co2, co3;
  logic [7:0]  s0, s1, s2;
  logic [15:0] s3;

  int tests_run = 0;
  int failed    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]), .ci(ci_v[0]),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_v[0]),
`endif
    .busy(busy0), .done(done0), .s(s0), .co(co0));

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]), .ci(ci_v[1]),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_v[1]),
`endif
    .busy(busy1), .done(done1), .s(s1), .co(co1));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]), .ci(ci_v[2]),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_v[2]),
`endif
    .busy(busy2), .done(done2), .s(s2), .co(co2));

  digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]), .ci(ci_v[3]),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_v[3]),
`endif
    .busy(busy3), .done(done3), .s(s3), .co(co3));

  assign busy_v[0] = busy0;  assign busy_v[1] = busy1;
  assign busy_v[2] = busy2;  assign busy_v[3] = busy3;
  assign done_v[0] = done0;  assign done_v[1] = done1;
  assign done_v[2] = done2;  assign done_v[3] = done3;
  assign co_v[0]   = co0;    assign co_v[1]   = co1;
  assign co_v[2]   = co2;    assign co_v[3]   = co3;
  assign s_v[0]    = {8'h00, s0};
  assign s_v[1]    = {8'h00, s1};
  assign s_v[2]    = {8'h00, s2};
  assign s_v[3]    = s3;

  function automatic int w_of(input int k);
    if (k == 3) return 16;
    else return 8;
  endfunction

  function automatic int ndig_of(input int k);
    case (k)
      0: return 8;
      1: return 2;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  // Reference result as plain integers: {co,s} = a + b + ci (or a - b with borrow flag).
  function automatic logic [16:0] model(input int k, input logic [15:0] av, input logic [15:0] bv,
                                        input logic civ, input logic subv);
    int unsigned w    = w_of(k);
    int unsigned mask = (32'd1 << w) - 32'd1;
    int unsigned x    = av & mask;
    int unsigned y    = bv & mask;
    int unsigned r;
    if (subv) begin
      r = ((x - y) & mask) | ((x >= y) ? (32'd1 << w) : 32'd0);
    end else begin
      r = x + y + civ;
    end
    return {1'b0, 16'(r & mask)} | (((r >> w) & 32'd1) != 0 ? 17'h10000 : 17'h00000);
  endfunction

  // Runs one operation on instance k; reports result, latency and busy cycles.
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input logic subv,
                        output logic [15:0] s_got, output logic co_got,
                        output int lat, output int busy_n, output logic done_after);
    a_v[k] = av; b_v[k] = bv; ci_v[k] = civ; sub_v[k] = subv;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); ci_v[k] = 1'($urandom);
    sub_v[k] = 1'($urandom);
    lat = -1; busy_n = 0; s_got = 16'hxxxx; co_got = 1'bx;
    if (busy_v[k]) busy_n++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[k]) begin
        lat = c; s_got = s_v[k]; co_got = co_v[k];
        break;
      end
      if (busy_v[k]) busy_n++;
    end
    @(posedge clk); #1;
    done_after = done_v[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0; a_v[k] = 16'h0000; b_v[k] = 16'h0000; ci_v[k] = 1'b0; sub_v[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({busy_v[k], done_v[k], co_v[k], s_v[k]} !== 19'h00000) begin
        failed++;
        $display("FAIL reset inst%0d: busy=%b done=%b co=%b s=%h, want all zero",
                 k, busy_v[k], done_v[k], co_v[k], s_v[k]);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] sg; logic cg; int lat, bn; logic da;
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h10000 || lat != 8 || bn != 8 || da !== 1'b0) begin
      failed++;
      $display("FAIL ff_plus_01: co=%b s=%h lat=%0d busy=%0d done_after=%b, want co=1 s=0000 lat=8 busy=8 done_after=0",
               cg, sg, lat, bn, da);
    end
    run_op(0, 16'h005A, 16'h003C, 1'b1, 1'b0, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h00097 || lat != 8) begin
      failed++;
      $display("FAIL 5a_plus_3c_ci: co=%b s=%h lat=%0d, want co=0 s=0097 lat=8", cg, sg, lat);
    end
    run_op(1, 16'h00F0, 16'h0010, 1'b0, 1'b0, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h10000 || lat != 2 || bn != 2) begin
      failed++;
      $display("FAIL digit4: co=%b s=%h lat=%0d busy=%0d, want co=1 s=0000 lat=2 busy=2", cg, sg, lat, bn);
    end
    run_op(2, 16'h00F0, 16'h0010, 1'b0, 1'b0, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h10000 || lat != 1 || bn != 1 || da !== 1'b0) begin
      failed++;
      $display("FAIL digit8: co=%b s=%h lat=%0d busy=%0d, want co=1 s=0000 lat=1 busy=1", cg, sg, lat, bn);
    end
  endtask

  // start held high: accepted only from IDLE, so one operation per 10 cycles.
  task automatic test_back_to_back();
    int done_at[$]; int busy_n; int bad_s;
    busy_n = 0; bad_s = 0;
    a_v[0] = 16'h0012; b_v[0] = 16'h0034; ci_v[0] = 1'b0; sub_v[0] = 1'b0;
    start_v[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (busy_v[0]) busy_n++;
      if (done_v[0]) begin
        done_at.push_back(e);
        if (s_v[0] !== 16'h0046 || co_v[0] !== 1'b0) bad_s++;
      end
    end
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (done_at.size() != 2) begin
      failed++;
      $display("FAIL b2b_count: done pulses=%0d, want 2", done_at.size());
    end else begin
      tests_run++;
      if (done_at[0] != 9 || done_at[1] != 19) begin
        failed++;
        $display("FAIL b2b_spacing: done at edges %0d,%0d, want 9,19", done_at[0], done_at[1]);
      end
    end
    tests_run++;
    if (busy_n != 16 || bad_s != 0) begin
      failed++;
      $display("FAIL b2b_busy: busy cycles=%0d bad results=%0d, want 16 and 0", busy_n, bad_s);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] sg; logic cg; int lat, bn; logic da; int seen_done;
    a_v[0] = 16'h00FF; b_v[0] = 16'h0001; ci_v[0] = 1'b1; sub_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({busy_v[0], done_v[0], co_v[0], s_v[0]} !== 19'h00000) begin
      failed++;
      $display("FAIL abort_state: busy=%b done=%b co=%b s=%h, want all zero",
               busy_v[0], done_v[0], co_v[0], s_v[0]);
    end
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) seen_done++;
    end
    tests_run++;
    if (seen_done != 0) begin
      failed++;
      $display("FAIL abort_no_done: done pulses=%0d, want 0", seen_done);
    end
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h00002 || lat != 8) begin
      failed++;
      $display("FAIL after_abort: co=%b s=%h lat=%0d, want co=0 s=0002 lat=8", cg, sg, lat);
    end
  endtask

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [15:0] sg; logic cg; int lat, bn; logic da;
    run_op(0, 16'h0010, 16'h0001, 1'b0, 1'b1, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h1000F) begin
      failed++;
      $display("FAIL sub_10_01: co=%b s=%h, want co=1 s=000f", cg, sg);
    end
    run_op(0, 16'h0000, 16'h0001, 1'b1, 1'b1, sg, cg, lat, bn, da);
    tests_run++;
    if ({cg, sg} !== 17'h000FF) begin
      failed++;
      $display("FAIL sub_00_01: co=%b s=%h, want co=0 s=00ff", cg, sg);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] sg, av, bv; logic cg, civ, subv; int lat, bn; logic da;
    logic [16:0] exp;
    int errs;
    for (int k = 0; k < 4; k++) begin
      errs = 0;
      for (int n = 0; n < 1000; n++) begin
        av = 16'($urandom); bv = 16'($urandom); civ = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        subv = 1'($urandom);
`else
        subv = 1'b0;
`endif
        exp = model(k, av, bv, civ, subv);
        run_op(k, av, bv, civ, subv, sg, cg, lat, bn, da);
        tests_run++;
        if ({cg, sg} !== exp || lat != ndig_of(k)) begin
          failed++;
          if (errs < 5)
            $display("FAIL random inst%0d: a=%h b=%h ci=%b sub=%b got co=%b s=%h lat=%0d, want co=%b s=%h lat=%0d",
                     k, av, bv, civ, subv, cg, sg, lat, exp[16], exp[15:0], ndig_of(k));
          errs++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
